// File: rtl/stream_req_sched.sv
// Round-robin scheduler that shares one tag-interface request port among nstrms
// stream sources, with a limit on outstanding requests per stream returned as credits.
module stream_req_sched #(
    parameter int addr_width   = 64,
    parameter int nstrms       = 64,
    parameter int nstrms_width = $clog2(nstrms),
    parameter int max_out      = 8,
    parameter int cnt_width    = $clog2(max_out + 1)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [nstrms-1:0]              i_req_v,
    output logic [nstrms-1:0]              i_req_r,
    input  logic [nstrms*addr_width-1:0]   i_req_ea,
    output logic                           o_req_v,
    input  logic                           o_req_r,
    output logic [nstrms_width-1:0]        o_req_sid,
    output logic [addr_width-1:0]          o_req_ea,
    input  logic                           i_cred_v,
    input  logic [nstrms_width-1:0]        i_cred_sid,
    output logic                           o_idle,
    output logic                           o_err
);

    logic                    o_req_v_q, o_req_v_d;
    logic [nstrms_width-1:0] sid_q, sid_d;
    logic [addr_width-1:0]   ea_q, ea_d;
    logic [nstrms_width-1:0] ptr_q, ptr_d;
    logic [cnt_width-1:0]    cnt_q [nstrms];
    logic [cnt_width-1:0]    cnt_d [nstrms];
    logic                    idle_q, idle_d;
    logic                    err_q, err_d;

    logic [nstrms-1:0]       elig_s;
    logic                    hi_v_s, lo_v_s, gnt_v_s;
    logic [nstrms_width-1:0] hi_idx_s, lo_idx_s, gnt_idx_s;
    logic                    load_s, fire_s, all_zero_s;

    // Arbitration: find-first over the ptr-masked half, falling back to the unmasked half.
    always_comb begin
        hi_v_s   = 1'b0;
        lo_v_s   = 1'b0;
        hi_idx_s = '0;
        lo_idx_s = '0;
        for (int s = 0; s < nstrms; s++) begin
            elig_s[s] = i_req_v[s] & (cnt_q[s] < cnt_width'(max_out));
        end
        for (int s = nstrms - 1; s >= 0; s--) begin
            hi_idx_s = (elig_s[s] && (nstrms_width'(s) >= ptr_q)) ? nstrms_width'(s) : hi_idx_s;
            hi_v_s   = hi_v_s | (elig_s[s] && (nstrms_width'(s) >= ptr_q));
            lo_idx_s = elig_s[s] ? nstrms_width'(s) : lo_idx_s;
            lo_v_s   = lo_v_s | elig_s[s];
        end
        gnt_v_s   = hi_v_s | lo_v_s;
        gnt_idx_s = hi_v_s ? hi_idx_s : lo_idx_s;
        load_s    = ~o_req_v_q | o_req_r;
        fire_s    = load_s & gnt_v_s & ~reset;
        for (int s = 0; s < nstrms; s++) begin
            i_req_r[s] = fire_s & (gnt_idx_s == nstrms_width'(s));
        end
    end

    // Per-stream outstanding counters; a grant and a credit on the same stream cancel.
    always_comb begin
        cnt_d      = cnt_q;
        err_d      = err_q;
        all_zero_s = 1'b1;
        for (int s = 0; s < nstrms; s++) begin
            case ({fire_s && (gnt_idx_s == nstrms_width'(s)),
                   i_cred_v && (i_cred_sid == nstrms_width'(s))})
                2'b10: cnt_d[s] = cnt_q[s] + cnt_width'(1);
                2'b01: begin
                    if (cnt_q[s] == cnt_width'(0)) begin
                        err_d = 1'b1;
                    end else begin
                        cnt_d[s] = cnt_q[s] - cnt_width'(1);
                    end
                end
                default: cnt_d[s] = cnt_q[s];
            endcase
            all_zero_s = all_zero_s & (cnt_d[s] == cnt_width'(0));
        end
    end

    // Output stage next state: reloads whenever empty or being drained.
    always_comb begin
        o_req_v_d = o_req_v_q;
        sid_d     = sid_q;
        ea_d      = ea_q;
        ptr_d     = ptr_q;
        if (load_s) begin
            o_req_v_d = gnt_v_s;
            if (gnt_v_s) begin
                sid_d = gnt_idx_s;
                ea_d  = i_req_ea[gnt_idx_s*addr_width +: addr_width];
                ptr_d = (gnt_idx_s == nstrms_width'(nstrms - 1)) ? '0
                                                                  : gnt_idx_s + nstrms_width'(1);
            end else begin
                ptr_d = ptr_q;
            end
        end else begin
            o_req_v_d = o_req_v_q;
        end
        idle_d = ~o_req_v_d & all_zero_s;
    end

    // State registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            o_req_v_q <= 1'b0;
            sid_q     <= '0;
            ea_q      <= '0;
            ptr_q     <= '0;
            idle_q    <= 1'b1;
            err_q     <= 1'b0;
            for (int s = 0; s < nstrms; s++) begin
                cnt_q[s] <= '0;
            end
        end else begin
            o_req_v_q <= o_req_v_d;
            sid_q     <= sid_d;
            ea_q      <= ea_d;
            ptr_q     <= ptr_d;
            idle_q    <= idle_d;
            err_q     <= err_d;
            cnt_q     <= cnt_d;
        end
    end

    assign o_req_v   = o_req_v_q;
    assign o_req_sid = sid_q;
    assign o_req_ea  = ea_q;
    assign o_idle    = idle_q;
    assign o_err     = err_q;

endmodule

// File: tb/tb_stream_req_sched.sv
// Bench for stream_req_sched with 4 streams, max_out=2: vector table plus
// hand-written reset, spurious-credit and round-robin sequences.
module tb_stream_req_sched;

    logic         clk = 1'b0;
    logic         reset;
    logic [3:0]   req_v;
    logic [3:0]   req_r;
    logic [255:0] req_ea;
    logic         o_v;
    logic         o_r;
    logic [1:0]   o_sid;
    logic [63:0]  o_ea;
    logic         cv;
    logic [1:0]   csid;
    logic         idle;
    logic         err;

    always #5 clk = ~clk;

    stream_req_sched #(
        .addr_width(64),
        .nstrms    (4),
        .max_out   (2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .i_req_v   (req_v),
        .i_req_r   (req_r),
        .i_req_ea  (req_ea),
        .o_req_v   (o_v),
        .o_req_r   (o_r),
        .o_req_sid (o_sid),
        .o_req_ea  (o_ea),
        .i_cred_v  (cv),
        .i_cred_sid(csid),
        .o_idle    (idle),
        .o_err     (err)
    );

    typedef struct packed {
        logic [3:0] v;
        logic       rdy;
        logic       cv;
        logic [1:0] csid;
        logic [3:0] exp_r;
        logic       exp_ov;
        logic [1:0] exp_sid;
        logic       exp_idle;
        logic       exp_err;
    } vec_t;

    typedef struct packed {
        logic [1:0]  sid;
        logic [63:0] ea;
    } sb_t;

    sb_t  sbq[$];
    int   passed = 0;
    int   total  = 0;
    vec_t tbl[30];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Drive one cycle of stimulus (called just after a rising edge) and check it.
    task automatic apply(input vec_t t, input string tag);
        sb_t e;
        sb_t got;
        req_v = t.v;
        o_r   = t.rdy;
        cv    = t.cv;
        csid  = t.csid;
        @(negedge clk);
        chk({tag, ".i_req_r"}, 64'(req_r), 64'(t.exp_r));
        if (o_v && o_r) begin
            if (sbq.size() == 0) begin
                total++;
                $display("FAIL %s.sb_underflow: got output sid %0d expected none", tag, o_sid);
            end else begin
                got = sbq.pop_front();
                chk({tag, ".sb_sid"}, 64'(o_sid), 64'(got.sid));
                chk({tag, ".sb_ea"}, o_ea, got.ea);
            end
        end
        for (int s = 0; s < 4; s++) begin
            if (t.exp_r[s]) begin
                e.sid = 2'(s);
                e.ea  = 64'(s) * 64'h1000;
                sbq.push_back(e);
            end
        end
        @(posedge clk);
        #1;
        chk({tag, ".o_req_v"}, 64'(o_v), 64'(t.exp_ov));
        if (t.exp_ov) begin
            chk({tag, ".o_req_sid"}, 64'(o_sid), 64'(t.exp_sid));
            chk({tag, ".o_req_ea"}, o_ea, 64'(t.exp_sid) * 64'h1000);
        end
        chk({tag, ".o_idle"}, 64'(idle), 64'(t.exp_idle));
        chk({tag, ".o_err"}, 64'(err), 64'(t.exp_err));
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, ".o_req_v"}, 64'(o_v), 64'd0);
        chk({tag, ".i_req_r"}, 64'(req_r), 64'd0);
        chk({tag, ".o_idle"}, 64'(idle), 64'd1);
        chk({tag, ".o_err"}, 64'(err), 64'd0);
    endtask

    initial begin
        int   seq[3];
        vec_t t;
        seq = '{2, 3, 1};
        //              v     rdy   cv    csid  exp_r  ov    sid   idle  err
        tbl[0]  = '{4'b1111, 1'b1, 1'b0, 2'd0, 4'b0001, 1'b1, 2'd0, 1'b0, 1'b0};
        tbl[1]  = '{4'b1111, 1'b1, 1'b1, 2'd0, 4'b0010, 1'b1, 2'd1, 1'b0, 1'b0};
        tbl[2]  = '{4'b1111, 1'b1, 1'b1, 2'd1, 4'b0100, 1'b1, 2'd2, 1'b0, 1'b0};
        tbl[3]  = '{4'b1111, 1'b1, 1'b1, 2'd2, 4'b1000, 1'b1, 2'd3, 1'b0, 1'b0};
        tbl[4]  = '{4'b1111, 1'b1, 1'b1, 2'd3, 4'b0001, 1'b1, 2'd0, 1'b0, 1'b0};
        tbl[5]  = '{4'b1111, 1'b1, 1'b1, 2'd0, 4'b0010, 1'b1, 2'd1, 1'b0, 1'b0};
        tbl[6]  = '{4'b0000, 1'b1, 1'b1, 2'd1, 4'b0000, 1'b0, 2'd1, 1'b1, 1'b0};
        // Credit limit on stream 2.
        tbl[7]  = '{4'b0100, 1'b1, 1'b0, 2'd0, 4'b0100, 1'b1, 2'd2, 1'b0, 1'b0};
        tbl[8]  = '{4'b0100, 1'b1, 1'b0, 2'd0, 4'b0100, 1'b1, 2'd2, 1'b0, 1'b0};
        tbl[9]  = '{4'b0100, 1'b1, 1'b0, 2'd0, 4'b0000, 1'b0, 2'd2, 1'b0, 1'b0};
        tbl[10] = '{4'b0100, 1'b1, 1'b0, 2'd0, 4'b0000, 1'b0, 2'd2, 1'b0, 1'b0};
        tbl[11] = '{4'b0100, 1'b1, 1'b1, 2'd2, 4'b0000, 1'b0, 2'd2, 1'b0, 1'b0};
        tbl[12] = '{4'b0100, 1'b1, 1'b0, 2'd0, 4'b0100, 1'b1, 2'd2, 1'b0, 1'b0};
        tbl[13] = '{4'b0000, 1'b1, 1'b1, 2'd2, 4'b0000, 1'b0, 2'd2, 1'b0, 1'b0};
        tbl[14] = '{4'b0000, 1'b1, 1'b1, 2'd2, 4'b0000, 1'b0, 2'd2, 1'b1, 1'b0};
        // Grant and credit together on stream 3.
        tbl[15] = '{4'b1000, 1'b1, 1'b0, 2'd0, 4'b1000, 1'b1, 2'd3, 1'b0, 1'b0};
        tbl[16] = '{4'b1000, 1'b1, 1'b1, 2'd3, 4'b1000, 1'b1, 2'd3, 1'b0, 1'b0};
        tbl[17] = '{4'b1000, 1'b1, 1'b0, 2'd0, 4'b1000, 1'b1, 2'd3, 1'b0, 1'b0};
        tbl[18] = '{4'b0000, 1'b1, 1'b1, 2'd3, 4'b0000, 1'b0, 2'd3, 1'b0, 1'b0};
        tbl[19] = '{4'b0000, 1'b1, 1'b1, 2'd3, 4'b0000, 1'b0, 2'd3, 1'b1, 1'b0};
        // Backpressure with stream 1 held.
        tbl[20] = '{4'b0010, 1'b1, 1'b0, 2'd0, 4'b0010, 1'b1, 2'd1, 1'b0, 1'b0};
        tbl[21] = '{4'b0010, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b1, 2'd1, 1'b0, 1'b0};
        tbl[22] = '{4'b0010, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b1, 2'd1, 1'b0, 1'b0};
        tbl[23] = '{4'b0010, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b1, 2'd1, 1'b0, 1'b0};
        tbl[24] = '{4'b0010, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b1, 2'd1, 1'b0, 1'b0};
        tbl[25] = '{4'b0010, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b1, 2'd1, 1'b0, 1'b0};
        tbl[26] = '{4'b0010, 1'b1, 1'b0, 2'd0, 4'b0010, 1'b1, 2'd1, 1'b0, 1'b0};
        tbl[27] = '{4'b0000, 1'b1, 1'b1, 2'd1, 4'b0000, 1'b0, 2'd1, 1'b0, 1'b0};
        tbl[28] = '{4'b0000, 1'b1, 1'b1, 2'd1, 4'b0000, 1'b0, 2'd1, 1'b1, 1'b0};
        // Spurious credit to empty stream 0.
        tbl[29] = '{4'b0000, 1'b1, 1'b1, 2'd0, 4'b0000, 1'b0, 2'd1, 1'b1, 1'b1};

        req_ea = {64'h3000, 64'h2000, 64'h1000, 64'h0000};
        reset  = 1'b1;
        req_v  = 4'b1111;
        o_r    = 1'b1;
        cv     = 1'b0;
        csid   = 2'd0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_state("reset_hold");
        req_v = 4'b0000;
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 30; i++) begin
            apply(tbl[i], $sformatf("vec%0d", i));
        end

        // Other streams keep rotating while o_err stays set.
        for (int i = 0; i < 100; i++) begin
            t.v        = 4'b1110;
            t.rdy      = 1'b1;
            t.cv       = (i > 0) ? 1'b1 : 1'b0;
            t.csid     = (i > 0) ? 2'(seq[(i - 1) % 3]) : 2'd0;
            t.exp_r    = 4'(4'b0001 << seq[i % 3]);
            t.exp_ov   = 1'b1;
            t.exp_sid  = 2'(seq[i % 3]);
            t.exp_idle = 1'b0;
            t.exp_err  = 1'b1;
            apply(t, $sformatf("rr_err%0d", i));
        end
        t = '{4'b0000, 1'b1, 1'b1, 2'(seq[0]), 4'b0000, 1'b0, 2'd0, 1'b1, 1'b1};
        apply(t, "drain");

        // Mid-operation asynchronous reset with a request held.
        t = '{4'b1111, 1'b1, 1'b0, 2'd0, 4'b1000, 1'b1, 2'd3, 1'b0, 1'b1};
        apply(t, "pre_rst");
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk_reset_state("async_rst");
        sbq.delete();
        repeat (3) begin
            @(posedge clk);
            #1;
            chk_reset_state("rst_held");
        end
        req_v = 4'b0000;
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        // A stale credit after reset is flagged.
        t = '{4'b0000, 1'b1, 1'b1, 2'd3, 4'b0000, 1'b0, 2'd0, 1'b1, 1'b1};
        apply(t, "stale_cred");
        chk("sb_leftover", 64'(sbq.size()), 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
